// File: rtl/johnson_step_ctrl.sv
// Command-driven sequencer for a Johnson-coded phase register.
// It accepts a move (step count, direction, rate divider) and steps the phase at the programmed rate.
module johnson_step_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [CNT_W-1:0] steps_r, steps_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic             dir_r, dir_s;
  logic             aborted_r, aborted_s;

  function automatic logic [WIDTH-1:0] johnson_fwd(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], ~q[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] johnson_rev(input logic [WIDTH-1:0] q);
    return {~q[0], q[WIDTH-1:1]};
  endfunction

  // Next-state and datapath update; abort outranks a step due on the same edge.
  always_comb begin
    state_s   = state_r;
    q_s       = q_r;
    steps_s   = steps_r;
    div_s     = div_r;
    div_cnt_s = div_cnt_r;
    dir_s     = dir_r;
    aborted_s = aborted_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          dir_s     = cmd_dir;
          div_s     = cmd_div;
          div_cnt_s = cmd_div;
          steps_s   = cmd_steps;
          aborted_s = 1'b0;
          if (cmd_steps == CNT_ZERO) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s   = DONE;
          aborted_s = 1'b1;
        end else if (div_cnt_r == DIV_ZERO) begin
          if (dir_r) begin
            q_s = johnson_fwd(q_r);
          end else begin
            q_s = johnson_rev(q_r);
          end
          steps_s   = steps_r - CNT_ONE;
          div_cnt_s = div_r;
          if (steps_r == CNT_ONE) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          div_cnt_s = div_cnt_r - DIV_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      q_r       <= {WIDTH{1'b0}};
      steps_r   <= CNT_ZERO;
      div_r     <= DIV_ZERO;
      div_cnt_r <= DIV_ZERO;
      dir_r     <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      q_r       <= q_s;
      steps_r   <= steps_s;
      div_r     <= div_s;
      div_cnt_r <= div_cnt_s;
      dir_r     <= dir_s;
      aborted_r <= aborted_s;
    end
  end

  assign cmd_ready  = (state_r == IDLE);
  assign busy       = (state_r == RUN);
  assign done       = (state_r == DONE);
  assign aborted    = aborted_r;
  assign Q          = q_r;
  assign steps_left = steps_r;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Directed self-checking bench for johnson_step_ctrl.
// Inputs change 1ns after each rising edge and outputs are checked there too.
module tb_johnson_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_steps;
  logic       cmd_dir;
  logic [7:0] cmd_div;
  logic       abort;
  logic [3:0] Q;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] steps_left;

  int compared = 0;
  int mismatched = 0;

  johnson_step_ctrl #(.WIDTH(4), .CNT_W(8), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_div(cmd_div), .abort(abort),
    .Q(Q), .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] exp);
    chk(tag, {4'h0, Q}, {4'h0, exp});
  endtask

  // Packed status: {cmd_ready, busy, done, aborted}
  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, {4'h0, cmd_ready, busy, done, aborted}, {4'h0, exp});
  endtask

  task automatic issue(input logic [7:0] steps, input logic dir, input logic [7:0] div);
    cmd_valid = 1'b1;
    cmd_steps = steps;
    cmd_dir   = dir;
    cmd_div   = div;
    tick();
    cmd_valid = 1'b0;
    cmd_steps = 8'hEE;
    cmd_dir   = ~dir;
    cmd_div   = 8'hEE;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] fwd_seq [8];
    fwd_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    reset = 1'b1; cmd_valid = 1'b0; cmd_steps = 8'd0; cmd_dir = 1'b0; cmd_div = 8'd0; abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_q("rst_q", 4'b0000);
    chk_st("rst_status", 4'b1000);
    chk("rst_steps_left", steps_left, 8'd0);

    // Three forward steps at full rate
    issue(8'd3, 1'b1, 8'd0);
    chk_st("t1_accept_status", 4'b0100);
    chk_q("t1_accept_q", 4'b0000);
    chk("t1_accept_left", steps_left, 8'd3);
    tick(); chk_q("t1_step1", 4'b0001);
    tick(); chk_q("t1_step2", 4'b0011);
    tick(); chk_q("t1_step3", 4'b0111);
    chk_st("t1_done", 4'b0010);
    chk("t1_done_left", steps_left, 8'd0);
    tick(); chk_st("t1_idle", 4'b1000);
    chk_q("t1_idle_q", 4'b0111);

    // Full forward cycle then two reverse steps
    do_reset();
    chk_q("t2_reset_q", 4'b0000);
    issue(8'd8, 1'b1, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_q($sformatf("t2_fwd%0d", i + 1), fwd_seq[i]);
    end
    chk_st("t2_done", 4'b0010);
    tick();
    issue(8'd2, 1'b0, 8'd0);
    tick(); chk_q("t2_rev1", 4'b1000);
    tick(); chk_q("t2_rev2", 4'b1100);
    chk_st("t2_rev_done", 4'b0010);
    tick();

    // Divided rate: step every 3 cycles, busy for 6 cycles
    issue(8'd2, 1'b1, 8'd2);
    chk_q("t3_c0", 4'b1100); chk_st("t3_busy0", 4'b0100);
    tick(); chk_q("t3_c1", 4'b1100); chk_st("t3_busy1", 4'b0100);
    tick(); chk_q("t3_c2", 4'b1100); chk_st("t3_busy2", 4'b0100);
    tick(); chk_q("t3_c3", 4'b1000); chk_st("t3_busy3", 4'b0100);
    tick(); chk_q("t3_c4", 4'b1000); chk_st("t3_busy4", 4'b0100);
    tick(); chk_q("t3_c5", 4'b1000); chk_st("t3_busy5", 4'b0100);
    tick(); chk_q("t3_c6", 4'b0000); chk_st("t3_done", 4'b0010);
    tick(); chk_st("t3_idle", 4'b1000);

    // Zero-step command completes immediately
    issue(8'd0, 1'b1, 8'd5);
    chk_st("t4_zero_done", 4'b0010);
    chk_q("t4_zero_q", 4'b0000);
    tick(); chk_st("t4_zero_idle", 4'b1000);

    // Command pulsed while busy is ignored
    issue(8'd2, 1'b1, 8'd0);
    cmd_valid = 1'b1; cmd_steps = 8'd5; cmd_dir = 1'b0;
    tick(); chk_q("t4_ign_step1", 4'b0001);
    cmd_valid = 1'b0;
    tick(); chk_q("t4_ign_step2", 4'b0011);
    chk_st("t4_ign_done", 4'b0010);
    tick(); chk_st("t4_ign_idle", 4'b1000);
    tick(); chk_q("t4_ign_hold", 4'b0011);
    chk("t4_ign_left", steps_left, 8'd0);

    // Abort on the 4th step edge
    do_reset();
    issue(8'd10, 1'b1, 8'd0);
    tick(); tick(); tick();
    chk_q("t5_pre_abort", 4'b0111);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_q("t5_abort_q", 4'b0111);
    chk("t5_abort_left", steps_left, 8'd7);
    chk_st("t5_abort_status", 4'b0011);
    tick(); chk_st("t5_idle_held", 4'b1001);

    // Reset in the middle of a move
    issue(8'd5, 1'b1, 8'd0);
    tick(); chk_q("t6_moving", 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_q("t6_reset_q", 4'b0000);
    chk_st("t6_reset_status", 4'b1000);
    chk("t6_reset_left", steps_left, 8'd0);
    tick(); chk_st("t6_no_done", 4'b1000);

    // Back-to-back: cmd_valid held high across DONE
    cmd_valid = 1'b1; cmd_steps = 8'd1; cmd_dir = 1'b1; cmd_div = 8'd0;
    tick(); tick();
    chk_st("t7_first_done", 4'b0010);
    tick(); chk_st("t7_idle", 4'b1000);
    tick();
    cmd_valid = 1'b0;
    chk_st("t7_second_accept", 4'b0100);
    tick(); chk_q("t7_second_step", 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
